// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD event counter advanced by an exact-period internal prescaler tick.
// Latency: bcd/wrap update on the edge ending the tick_out cycle; tick_out and seg are combinational.
// Backpressure: none; enable=0 freezes prescaler and count, clear/load override the tick.
module bcd_tick_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int DIGITS   = 2,
    parameter int DIV_W    = 26
) (
    input  logic                  clock,
    input  logic                  Resetn,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick_out,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   seg
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]    prescaler;
    logic                tick;
    logic [4*DIGITS-1:0] bcd_step;
    logic [4*DIGITS-1:0] load_clean;
    logic                step_wrap;

    assign tick     = enable && (prescaler == DIV_LAST);
    assign tick_out = tick && !clear && !load;

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= tick ? '0 : prescaler + DIV_W'(1);
        end
    end

    // Ripple the carry/borrow through the digits; a carry out of the top digit is a full wrap.
    always_comb begin : step_logic
        logic carry;
        carry      = 1'b1;
        bcd_step   = '0;
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!carry) begin
                bcd_step[4*i +: 4] = bcd[4*i +: 4];
            end else if (up_down) begin
                if (bcd[4*i +: 4] >= 4'd9) begin
                    bcd_step[4*i +: 4] = 4'd0;
                end else begin
                    bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end else begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    bcd_step[4*i +: 4] = 4'd9;
                end else begin
                    bcd_step[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    carry              = 1'b0;
                end
            end
            load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
        end
        step_wrap = carry;
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            bcd  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            bcd  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bcd  <= load_clean;
            wrap <= 1'b0;
        end else if (tick) begin
            bcd  <= bcd_step;
            wrap <= step_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

    // Active-low glyphs, bit order g..a; anything above 9 blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign seg[7*g +: 7] = seg_decode(bcd[4*g +: 4]);
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Randomised and directed checks of bcd_tick_counter against an integer-arithmetic model.
module tb_bcd_tick_counter;

    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 2;
    localparam int DIV_W    = 3;
    localparam int VW       = 2 + 11 * DIGITS;

    localparam logic [6:0] GLYPH [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic                clock = 1'b0;
    logic                Resetn;
    logic                enable;
    logic                up_down;
    logic                clear;
    logic                load;
    logic [4*DIGITS-1:0] load_value;
    logic [4*DIGITS-1:0] bcd;
    logic                tick_out;
    logic                wrap;
    logic [7*DIGITS-1:0] seg;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt;
    int m_pre;
    bit m_wrap;

    bcd_tick_counter #(.TICK_DIV(TICK_DIV), .DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
        .clock(clock), .Resetn(Resetn), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .bcd(bcd), .tick_out(tick_out), .wrap(wrap), .seg(seg)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int sanitize(input logic [4*DIGITS-1:0] lv);
        int v;
        int w;
        int d;
        v = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v += d * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [4*DIGITS-1:0] b;
        logic [7*DIGITS-1:0] s;
        logic                tk;
        int v;
        v  = m_cnt;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            s[7*i +: 7] = GLYPH[v % 10];
            v = v / 10;
        end
        tk = enable && (m_pre == TICK_DIV - 1) && !clear && !load;
        return {tk, m_wrap, b, s};
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_pre  = 0;
        m_wrap = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs that were applied during the cycle.
    function automatic void model_step();
        int modn;
        bit tk;
        modn = 10 ** DIGITS;
        tk   = enable && (m_pre == TICK_DIV - 1);
        if (clear) begin
            model_reset();
        end else begin
            if (enable) m_pre = (m_pre + 1) % TICK_DIV;
            if (load) begin
                m_cnt  = sanitize(load_value);
                m_wrap = 1'b0;
            end else if (tk && up_down) begin
                m_wrap = (m_cnt == modn - 1);
                m_cnt  = (m_cnt + 1) % modn;
            end else if (tk) begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + modn - 1) % modn;
            end else begin
                m_wrap = 1'b0;
            end
        end
    endfunction

    task automatic test_reset();
        Resetn = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
        model_reset();
        #1;
        n_cmp++;
        if ({tick_out, wrap, bcd, seg} !== {1'b0, 1'b0, 8'h00, {2{7'b1000000}}}) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", {tick_out, wrap, bcd, seg}, {1'b0, 1'b0, 8'h00, {2{7'b1000000}}});
        end
        @(posedge clock); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_count_up();
        int ticks;
        ticks = 0;
        enable = 1'b1; up_down = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL count_up cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            if (tick_out) ticks++;
            @(posedge clock); model_step(); #1;
        end
        n_cmp++;
        if (ticks != 12 || bcd !== 8'h12) begin
            n_bad++;
            $display("FAIL count_up_total: got ticks=%0d bcd=%h want ticks=12 bcd=12", ticks, bcd);
        end
    endtask

    task automatic test_wrap_up();
        int wraps;
        wraps = 0;
        for (int c = 0; c < 12; c++) begin
            load = (c == 0); load_value = 8'h98;
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_up cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            if (wrap) wraps++;
            @(posedge clock); model_step(); #1;
        end
        load = 1'b0;
        n_cmp++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL wrap_up_pulses: got %0d want 1", wraps);
        end
    endtask

    task automatic test_down();
        for (int c = 0; c < 9; c++) begin
            clear   = (c == 0);
            up_down = (c == 0);
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL down cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            @(posedge clock); model_step(); #1;
        end
        n_cmp++;
        if (bcd !== 8'h98) begin
            n_bad++;
            $display("FAIL down_second_tick: got %h want 98", bcd);
        end
    endtask

    task automatic test_pause();
        int wait_n;
        bit seen;
        wait_n = 0;
        seen = 1'b0;
        up_down = 1'b1;
        for (int c = 0; c < 12; c++) begin
            enable = (c < 2);
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL pause cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            @(posedge clock); model_step(); #1;
        end
        enable = 1'b1;
        while (!seen && wait_n < 10) begin
            wait_n++;
            @(negedge clock);
            seen = tick_out;
            @(posedge clock); model_step(); #1;
        end
        n_cmp++;
        if (!seen || wait_n != 2) begin
            n_bad++;
            $display("FAIL pause_resume: got tick after %0d cycles (seen=%0b) want 2", wait_n, seen);
        end
    endtask

    task automatic test_load_tick();
        int wait_n;
        bit seen;
        enable = 1'b1; up_down = 1'b1;
        for (int c = 0; c < TICK_DIV && m_pre != TICK_DIV - 1; c++) begin
            @(posedge clock); model_step(); #1;
        end
        load = 1'b1; load_value = 8'hA7;
        @(negedge clock);
        n_cmp++;
        if ({tick_out, wrap, bcd, seg} !== exp_vec() || tick_out !== 1'b0) begin
            n_bad++;
            $display("FAIL load_tick_cycle: got %h want %h", {tick_out, wrap, bcd, seg}, exp_vec());
        end
        @(posedge clock); model_step(); #1;
        n_cmp++;
        if (bcd !== 8'h07) begin
            n_bad++;
            $display("FAIL load_tick_value: got %h want 07", bcd);
        end
        repeat (2) begin
            @(posedge clock); model_step(); #1;
        end
        clear = 1'b1; load = 1'b1; load_value = 8'h55;
        @(posedge clock); model_step(); #1;
        clear = 1'b0; load = 1'b0;
        n_cmp++;
        if (bcd !== 8'h00) begin
            n_bad++;
            $display("FAIL clear_over_load: got %h want 00", bcd);
        end
        wait_n = 0;
        seen = 1'b0;
        while (!seen && wait_n < 10) begin
            wait_n++;
            @(negedge clock);
            seen = tick_out;
            @(posedge clock); model_step(); #1;
        end
        n_cmp++;
        if (!seen || wait_n != TICK_DIV) begin
            n_bad++;
            $display("FAIL clear_prescaler: got tick after %0d cycles (seen=%0b) want %0d", wait_n, seen, TICK_DIV);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enable     = ($urandom_range(0, 9) != 0);
            up_down    = $urandom_range(0, 1) == 1;
            clear      = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 29) == 0);
            load_value = 8'($urandom);
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            @(posedge clock); model_step(); #1;
        end
        clear = 1'b0; load = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_value = 8'h56; enable = 1'b0;
        @(posedge clock); model_step(); #1;
        load = 1'b0;
        n_cmp++;
        if (bcd !== 8'h56) begin
            n_bad++;
            $display("FAIL preload_56: got %h want 56", bcd);
        end
        #2;
        Resetn = 1'b0;
        #1;
        n_cmp++;
        if ({wrap, bcd, seg} !== {1'b0, 8'h00, {2{7'b1000000}}}) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", {wrap, bcd, seg}, {1'b0, 8'h00, {2{7'b1000000}}});
        end
        @(posedge clock); #1;
        Resetn = 1'b1;
        model_reset();
        enable = 1'b1; up_down = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({tick_out, wrap, bcd, seg} !== exp_vec()) begin
                n_bad++;
                $display("FAIL after_reset cycle %0d: got %h want %h", c, {tick_out, wrap, bcd, seg}, exp_vec());
            end
            @(posedge clock); model_step(); #1;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_down();
        test_pause();
        test_load_tick();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
